// File: rtl/wireframe_fb_arbiter.sv
// wireframe_fb_arbiter
//
// Shares the single port of the 1-bit wireframe framebuffer SRAM between three requesters.
// Fixed priority: scanout read > full-frame clear engine > rasterizer pixel write.
//
// Optional build macro: WFB_ARB_PERF_EN adds the px_stall_cnt output, a saturating count of
// cycles where the rasterizer wanted to write but was held off.
//
// Ports:
//   clk, n_rst                 clock (rising edge), asynchronous active-low reset
//   clear_req                  single-cycle request to zero the whole frame
//   clear_busy, clear_done     clear engine active / one-cycle completion pulse
//   px_valid/px_addr/px_data   rasterizer write request; px_ready is the accept handshake
//   scan_valid/scan_addr       scanout read request, always granted
//   scan_data/scan_data_valid  read result, one cycle after scan_valid
//   sram_write_en/data_in/addr SRAM port controls (owned by this block)
//   sram_data_out              SRAM read data, one-cycle latency
//   px_stall_cnt               (WFB_ARB_PERF_EN only) stalled-write cycle count

module wireframe_fb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned FB_PIXELS  = 640 * 480
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  px_valid,
    input  logic [ADDR_WIDTH-1:0] px_addr,
    input  logic                  px_data,
    output logic                  px_ready,
    input  logic                  scan_valid,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    output logic                  scan_data,
    output logic                  scan_data_valid,
    output logic                  sram_write_en,
    output logic                  sram_data_in,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic                  sram_data_out
`ifdef WFB_ARB_PERF_EN
    ,
    output logic [31:0]           px_stall_cnt
`endif
);

    // Compared at ADDR_WIDTH bits so the clear counter stops exactly at the last pixel.
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FB_PIXELS - 1);
    // One extra bit so FB_PIXELS itself is representable for the range checks.
    localparam logic [ADDR_WIDTH:0]   FbLimit  = (ADDR_WIDTH + 1)'(FB_PIXELS);

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clear_cnt_q;
    logic                  clear_done_q;
    logic                  scan_valid_q;
    logic                  scan_oor_q;
    logic                  px_in_range;
    logic                  scan_in_range;

    assign px_in_range   = {1'b0, px_addr} < FbLimit;
    assign scan_in_range = {1'b0, scan_addr} < FbLimit;

    // Clear FSM. The counter only advances on cycles where the clear owns the port.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            clear_cnt_q  <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_req) begin
                        state_q     <= StClear;
                        clear_cnt_q <= '0;
                    end
                end
                StClear: begin
                    if (!scan_valid) begin
                        if (clear_cnt_q == LastAddr) begin
                            state_q      <= StIdle;
                            clear_done_q <= 1'b1;
                        end else begin
                            clear_cnt_q <= clear_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign clear_busy = (state_q == StClear);
    assign clear_done = clear_done_q;

    // Scanout return path: the SRAM answers one cycle later, so remember whether the
    // request was valid and whether it fell outside the frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scan_valid_q <= 1'b0;
            scan_oor_q   <= 1'b0;
        end else begin
            scan_valid_q <= scan_valid;
            scan_oor_q   <= scan_valid && !scan_in_range;
        end
    end

    assign scan_data_valid = scan_valid_q;
    assign scan_data       = scan_valid_q && !scan_oor_q && sram_data_out;

    // Port grant. Gated by n_rst so the SRAM sees an idle port while reset is held.
    always_comb begin
        sram_write_en = 1'b0;
        sram_data_in  = 1'b0;
        sram_addr     = '0;
        px_ready      = 1'b0;
        if (n_rst) begin
            px_ready = !scan_valid && (state_q == StIdle);
            if (scan_valid) begin
                sram_addr = scan_addr;
            end else if (state_q == StClear) begin
                sram_addr     = clear_cnt_q;
                sram_write_en = 1'b1;
            end else if (px_valid) begin
                // Out-of-range writes are still handshaken, just never reach the SRAM.
                sram_addr     = px_addr;
                sram_data_in  = px_data;
                sram_write_en = px_in_range;
            end
        end
    end

`ifdef WFB_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == StIdle) && clear_req) begin
            stall_cnt_q <= '0;
        end else if (px_valid && !px_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign px_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wireframe_fb_arbiter.sv
// Testbench for wireframe_fb_arbiter: directed vector table, clear-engine sequences,
// mid-operation reset, and randomized traffic against a framebuffer-level reference model.
// Build with WFB_ARB_PERF_EN defined to also exercise px_stall_cnt.

module tb_wireframe_fb_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned FB = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          clear_req = 1'b0;
    logic          clear_busy;
    logic          clear_done;
    logic          px_valid = 1'b0;
    logic [AW-1:0] px_addr = '0;
    logic          px_data = 1'b0;
    logic          px_ready;
    logic          scan_valid = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic          scan_data;
    logic          scan_data_valid;
    logic          sram_write_en;
    logic          sram_data_in;
    logic [AW-1:0] sram_addr;
    logic          sram_data_out = 1'b0;
`ifdef WFB_ARB_PERF_EN
    logic [31:0]   px_stall_cnt;
`endif

    wireframe_fb_arbiter #(
        .ADDR_WIDTH (AW),
        .FB_PIXELS  (FB)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_req       (clear_req),
        .clear_busy      (clear_busy),
        .clear_done      (clear_done),
        .px_valid        (px_valid),
        .px_addr         (px_addr),
        .px_data         (px_data),
        .px_ready        (px_ready),
        .scan_valid      (scan_valid),
        .scan_addr       (scan_addr),
        .scan_data       (scan_data),
        .scan_data_valid (scan_data_valid),
        .sram_write_en   (sram_write_en),
        .sram_data_in    (sram_data_in),
        .sram_addr       (sram_addr),
        .sram_data_out   (sram_data_out)
`ifdef WFB_ARB_PERF_EN
        ,
        .px_stall_cnt    (px_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural SRAM. Locations past the frame hold 1 so forced-zero reads are visible.
    logic mem [0:31];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = (i >= FB) ? 1'b1 : 1'b0;
    end
    always @(posedge clk) begin
        if (sram_write_en) mem[sram_addr[4:0]] <= sram_data_in;
        sram_data_out <= mem[sram_addr[4:0]];
    end

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    // Reference model: frame image plus clear progress, from the priority rules.
    bit     m_clr = 0;
    int     m_next = 0;
    bit     m_done = 0;
    bit     m_sv = 0;
    bit     m_rd = 0;
    longint m_stall = 0;
    int     m_img [0:31];
    initial for (int i = 0; i < 32; i++) m_img[i] = 0;

    function automatic void model_reset();
        m_clr = 0;
        m_done = 0;
        m_sv = 0;
        m_stall = 0;
    endfunction

    function automatic void check_model();
        bit want_rdy;
        bit want_we;
        int want_addr;
        bit want_din;
        want_rdy  = !scan_valid && !m_clr;
        want_we   = 0;
        want_addr = 0;
        want_din  = 0;
        if (scan_valid) begin
            want_addr = int'(scan_addr);
        end else if (m_clr) begin
            want_addr = m_next;
            want_we   = 1;
        end else if (px_valid) begin
            want_addr = int'(px_addr);
            want_din  = px_data;
            want_we   = (int'(px_addr) < FB);
        end
        chk("px_ready", px_ready, want_rdy);
        chk("sram_write_en", sram_write_en, want_we);
        chk("sram_addr", sram_addr, want_addr);
        if (want_we) chk("sram_data_in", sram_data_in, want_din);
        chk("clear_busy", clear_busy, m_clr);
        chk("clear_done", clear_done, m_done);
        chk("scan_data_valid", scan_data_valid, m_sv);
        chk("scan_data", scan_data, m_sv ? m_rd : 1'b0);
`ifdef WFB_ARB_PERF_EN
        chk("px_stall_cnt", px_stall_cnt, m_stall[31:0]);
`endif
    endfunction

    function automatic void update_model();
        bit acc;
        bit rdy;
        acc = !m_clr && clear_req;
        rdy = !scan_valid && !m_clr;
        if (acc) m_stall = 0;
        else if (px_valid && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_sv = scan_valid;
        if (scan_valid) m_rd = (int'(scan_addr) < FB) ? m_img[scan_addr[4:0]][0] : 1'b0;
        m_done = 0;
        if (m_clr) begin
            if (!scan_valid) begin
                m_img[m_next] = 0;
                if (m_next == FB - 1) begin
                    m_clr  = 0;
                    m_done = 1;
                end else begin
                    m_next++;
                end
            end
        end else begin
            if (!scan_valid && px_valid && int'(px_addr) < FB) m_img[px_addr[4:0]] = int'(px_data);
            if (clear_req) begin
                m_clr  = 1;
                m_next = 0;
            end
        end
    endfunction

    typedef struct {
        logic sv;  int sa;
        logic pv;  int pa;  logic pd;
        logic rdy; logic we; int addr; logic din; logic sdv; logic sd;
    } vec_t;
    vec_t tbl [0:9];

    logic          obs_busy, obs_done, obs_rdy, obs_we;
    logic [AW-1:0] obs_addr;

    // Called just after a falling edge with inputs already driven.
    task automatic step(input int row);
        #4;
        check_model();
        if (row >= 0) begin
            chk($sformatf("tbl%0d_ready", row), px_ready, tbl[row].rdy);
            chk($sformatf("tbl%0d_we", row), sram_write_en, tbl[row].we);
            chk($sformatf("tbl%0d_addr", row), sram_addr, tbl[row].addr);
            if (tbl[row].we) chk($sformatf("tbl%0d_din", row), sram_data_in, tbl[row].din);
            chk($sformatf("tbl%0d_sdv", row), scan_data_valid, tbl[row].sdv);
            chk($sformatf("tbl%0d_sd", row), scan_data, tbl[row].sd);
        end
        obs_busy = clear_busy;
        obs_done = clear_done;
        obs_rdy  = px_ready;
        obs_we   = sram_write_en;
        obs_addr = sram_addr;
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, sram_write_en, 0);
        chk({tag, "_din"}, sram_data_in, 0);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_ready"}, px_ready, 0);
        chk({tag, "_busy"}, clear_busy, 0);
        chk({tag, "_done"}, clear_done, 0);
        chk({tag, "_sdv"}, scan_data_valid, 0);
        chk({tag, "_sd"}, scan_data, 0);
    endtask

    task automatic run_clear(input bit steal, input bit px_hold, input int want_busy);
        int busy = 0;
        int writes = 0;
        int addr_bad = 0;
        int ready_bad = 0;
        int done_cnt = 0;
        int done_pos_bad = 0;
        bit prev_busy = 0;
        scan_valid = 0;
        px_valid   = 0;
        clear_req  = 1;
        step(-1);
        clear_req = 0;
        for (int i = 0; i < 60; i++) begin
            scan_valid = steal && i >= 5 && i < 9;
            scan_addr  = 3;
            px_valid   = px_hold && i >= 2 && i < 6;
            px_addr    = 3;
            px_data    = 1;
            step(-1);
            if (obs_busy) begin
                busy++;
                if (obs_rdy) ready_bad++;
                if (obs_we) begin
                    if (int'(obs_addr) != writes) addr_bad++;
                    writes++;
                end
            end
            if (obs_done) begin
                done_cnt++;
                if (!prev_busy || obs_busy) done_pos_bad++;
            end
            prev_busy = obs_busy;
            if (obs_done) break;
        end
        scan_valid = 0;
        px_valid   = 0;
        chk("clear_busy_cycles", busy, want_busy);
        chk("clear_write_count", writes, FB);
        chk("clear_addr_noncontig", addr_bad, 0);
        chk("clear_px_ready_high", ready_bad, 0);
        chk("clear_done_pulses", done_cnt, 1);
        chk("clear_done_position", done_pos_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             sv sa  pv pa  pd  rdy we addr din sdv sd
        tbl[0] = '{1'b0, 0, 1'b1, 10, 1'b1, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 10, 1'b0, 0, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 16, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 5, 1'b1, 7, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 0, 1'b1, 7, 1'b1, 1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 0, 1'b1, 16, 1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 7, 1'b0, 0, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};

        // Reset state, with live requests that must not leak through.
        scan_valid = 1;
        scan_addr  = 5;
        px_valid   = 1;
        px_addr    = 3;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        scan_valid = 0;
        px_valid   = 0;
        n_rst      = 1;

        for (int r = 0; r < 10; r++) begin
            scan_valid = tbl[r].sv;
            scan_addr  = AW'(tbl[r].sa);
            px_valid   = tbl[r].pv;
            px_addr    = AW'(tbl[r].pa);
            px_data    = tbl[r].pd;
            step(r);
        end
        scan_valid = 0;
        px_valid   = 0;

        run_clear(1'b0, 1'b0, FB);
        run_clear(1'b1, 1'b0, FB + 4);
        run_clear(1'b0, 1'b1, FB);
`ifdef WFB_ARB_PERF_EN
        #4;
        chk("perf_stall_after_clear", px_stall_cnt, 4);
        @(negedge clk);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            scan_valid = ($urandom_range(0, 9) < 3);
            scan_addr  = AW'($urandom_range(0, 19));
            px_valid   = $urandom_range(0, 1);
            px_addr    = AW'($urandom_range(0, 19));
            px_data    = $urandom_range(0, 1);
            clear_req  = ($urandom_range(0, 59) == 0);
            step(-1);
        end
        clear_req  = 0;
        scan_valid = 0;
        px_valid   = 0;
        for (int i = 0; i < 40 && m_clr; i++) step(-1);

        // Reset mid-clear aborts it.
        for (int i = 0; i < 4; i++) begin
            px_data    = 1;
            px_addr    = AW'(i);
            px_valid   = 1;
            step(-1);
        end
        px_valid  = 0;
        clear_req = 1;
        step(-1);
        clear_req = 0;
        step(-1);
        step(-1);
        step(-1);
        scan_valid = 1;
        scan_addr  = 9;
        px_valid   = 1;
        px_addr    = 2;
        #2;
        n_rst = 0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        scan_valid = 0;
        px_valid   = 0;
        n_rst      = 1;
        step(-1);
        chk("post_rst_ready", obs_rdy, 1);
        chk("post_rst_busy", obs_busy, 0);

        // Read back the whole frame; model checks each returned pixel.
        for (int a = 0; a < FB + 2; a++) begin
            scan_valid = 1;
            scan_addr  = AW'(a);
            step(-1);
        end
        scan_valid = 0;
        step(-1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
